// File: rtl/spi_slave_core.sv
// SPI slave byte engine clocked entirely by clk_i: synchronized bus sampling,
// one-entry TX buffer, one-entry RX holding register, modes 0-3, MSB/LSB first.
module spi_slave_core #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsb_i,
    input  logic       spi_sck_i,
    input  logic       spi_nss_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_en_o,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       ovf_o,
    output logic       udf_o,
    output logic       abort_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync, sync_fill;
    logic       sck_s, nss_s, mosi_s;
    logic       sck_prev, nss_prev, armed;
    logic       cpol_q, cpha_q, lsb_q;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, rx_next;
    logic [7:0] tx_shift, tx_buf;
    logic       tx_full, load_pending;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic nss_fall, nss_rise, run, go_active;
    logic sample_edge, shift_edge, wrap, load, tx_accept, rx_fire, abort_set;

    // NOTE: every register below uses non-blocking assignments so that all
    // flops see pre-edge values of each other; blocking here would create order races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            nss_sync  <= '1;
            mosi_sync <= '0;
            sync_fill <= '0;
            sck_prev  <= 1'b0;
            nss_prev  <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            nss_prev  <= nss_s;
            // Only a real high level on the pin arms NSS-fall detection, so a
            // master still holding NSS low across reset is not mistaken for a new frame.
            if (sync_fill[SYNC_STAGES-1] && nss_s)
                armed <= 1'b1;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign nss_s  = nss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise   = sck_s & ~sck_prev;
    assign sck_fall   = ~sck_s & sck_prev;
    assign lead_edge  = cpol_q ? sck_fall : sck_rise;
    assign trail_edge = cpol_q ? sck_rise : sck_fall;
    assign nss_fall   = armed & nss_prev & ~nss_s;
    assign nss_rise   = nss_s & ~nss_prev;

    assign run         = (state == ACTIVE) && en_i && !nss_rise;
    assign sample_edge = run && (cpha_q ? trail_edge : lead_edge);
    // The first shift edge of each byte is skipped: its first bit is already
    // presented by the load that precedes it.
    assign shift_edge  = run && (cpha_q ? lead_edge : trail_edge) && (bit_cnt != 3'd0);
    assign wrap        = sample_edge && (bit_cnt == 3'd7);
    assign rx_next     = lsb_q ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};
    assign load        = go_active || (load_pending && run);
    assign tx_accept   = tx_valid_i && !tx_full;
    assign rx_fire     = rx_valid_o && rx_ready_i;
    assign abort_set   = (state == ACTIVE) && en_i && nss_rise && (bit_cnt != 3'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        next_state = state;
        go_active  = 1'b0;
        case (state)
            IDLE: begin
                if (en_i && nss_fall) begin
                    next_state = ACTIVE;
                    go_active  = 1'b1;
                end
            end
            ACTIVE: begin
                if (!en_i || nss_rise)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
        end else if (state == IDLE) begin
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            lsb_q  <= lsb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || next_state == IDLE)
            bit_cnt <= 3'd0;
        else if (sample_edge)
            bit_cnt <= bit_cnt + 3'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_shift   <= 8'h00;
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h00;
            ovf_o      <= 1'b0;
            abort_o    <= 1'b0;
        end else begin
            ovf_o   <= 1'b0;
            abort_o <= abort_set;
            if (sample_edge)
                rx_shift <= rx_next;
            if (!en_i) begin
                rx_valid_o <= 1'b0;
            end else if (wrap) begin
                if (!rx_valid_o || rx_fire) begin
                    rx_valid_o <= 1'b1;
                    rx_data_o  <= rx_next;
                end else begin
                    ovf_o <= 1'b1;
                end
            end else if (rx_fire) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_full      <= 1'b0;
            tx_buf       <= 8'h00;
            tx_shift     <= 8'h00;
            udf_o        <= 1'b0;
            load_pending <= 1'b0;
        end else begin
            udf_o        <= 1'b0;
            load_pending <= wrap;
            if (!en_i) begin
                tx_full <= 1'b0;
            end else begin
                if (load) begin
                    if (tx_full) begin
                        tx_shift <= tx_buf;
                        tx_full  <= 1'b0;
                    end else begin
                        tx_shift <= DUMMY_BYTE;
                        udf_o    <= 1'b1;
                    end
                end else if (shift_edge) begin
                    tx_shift <= lsb_q ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
                end
                if (tx_accept) begin
                    tx_buf  <= tx_data_i;
                    tx_full <= 1'b1;
                end
            end
        end
    end

    assign tx_ready_o    = ~tx_full;
    assign busy_o        = (state == ACTIVE);
    assign spi_miso_en_o = (state == ACTIVE);
    assign spi_miso_o    = (state == ACTIVE) ? (lsb_q ? tx_shift[0] : tx_shift[7]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives frames and
// results are compared against hand-computed bytes and event counts.
`timescale 1ns/1ps
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst, en, cpol, cpha, lsb;
    logic       sck, nss, mosi;
    logic       spi_miso_o, spi_miso_en_o;
    logic       tx_valid, tx_ready_o;
    logic [7:0] tx_data;
    logic       rx_valid_o, rx_ready;
    logic [7:0] rx_data_o;
    logic       busy_o, ovf_o, udf_o, abort_o;

    int n_checks = 0;
    int n_pass   = 0;
    int udf_cnt  = 0;
    int ovf_cnt  = 0;
    int abort_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] mi, mi2;

    spi_slave_core #(.SYNC_STAGES(2), .DUMMY_BYTE(8'hFF)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
        .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
        .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .ovf_o(ovf_o), .udf_o(udf_o), .abort_o(abort_o)
    );

    always #5 clk = ~clk;

    // Event monitor: samples just after the falling edge, well clear of posedge.
    always @(negedge clk) begin
        #1;
        if (udf_o)   udf_cnt++;
        if (ovf_o)   ovf_cnt++;
        if (abort_o) abort_cnt++;
        if (rx_valid_o && rx_ready) rx_q.push_back(rx_data_o);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p; cpha = h; lsb = l; sck = p;
        tick(8);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready_o && k < 50) begin
            tick(1);
            k++;
        end
        check("tx_push_wait", 32'(k < 50), 32'd1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start();
        nss = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic frame_end();
        nss = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic drain_rx();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    // Master side of one byte (or a partial byte of nbits) in the current mode.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
        logic [2:0] idx;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? 3'(i) : 3'(7 - i);
            if (!cpha) begin
                mosi = mo[idx];
                tick(HALF);
                got[idx] = spi_miso_o;
                sck = ~cpol;
                tick(HALF);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[idx];
                tick(HALF);
                got[idx] = spi_miso_o;
                sck = cpol;
                tick(HALF);
            end
        end
        tick(HALF);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        sck = 1'b0; nss = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        tick(4);

        check("rst_tx_ready", 32'(tx_ready_o), 32'd1);
        check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst_rx_data",  32'(rx_data_o), 32'h00);
        check("rst_miso",     32'(spi_miso_o), 32'd0);
        check("rst_miso_en",  32'(spi_miso_en_o), 32'd0);
        check("rst_busy",     32'(busy_o), 32'd0);
        check("rst_pulses",   32'({ovf_o, udf_o, abort_o}), 32'd0);
        rst = 1'b0;
        tick(6);

        // Mode 0, MSB first: A5 out, 3C in.
        set_mode(1'b0, 1'b0, 1'b0);
        udf_cnt = 0;
        push_tx(8'hA5);
        check("m0_tx_full", 32'(tx_ready_o), 32'd0);
        frame_start();
        check("m0_busy",    32'(busy_o), 32'd1);
        check("m0_miso_en", 32'(spi_miso_en_o), 32'd1);
        check("m0_consumed", 32'(tx_ready_o), 32'd1);
        push_tx(8'h00);
        spi_xfer(8'h3C, 8, mi);
        check("m0_miso", 32'(mi), 32'hA5);
        check("m0_rx_valid", 32'(rx_valid_o), 32'd1);
        check("m0_rx_data", 32'(rx_data_o), 32'h3C);
        frame_end();
        check("m0_udf", 32'(udf_cnt), 32'd0);
        check("m0_idle_busy", 32'(busy_o), 32'd0);
        check("m0_idle_miso", 32'({spi_miso_en_o, spi_miso_o}), 32'd0);
        drain_rx();
        check("m0_rx_cleared", 32'(rx_valid_o), 32'd0);

        // Mode 3, LSB first, back-to-back bytes with rx_ready held high.
        set_mode(1'b1, 1'b1, 1'b1);
        rx_q.delete();
        ovf_cnt = 0;
        rx_ready = 1'b1;
        frame_start();
        spi_xfer(8'h81, 8, mi);
        spi_xfer(8'h7E, 8, mi2);
        frame_end();
        rx_ready = 1'b0;
        check("m3_rx_count", 32'(rx_q.size()), 32'd2);
        check("m3_rx_byte0", 32'(rx_q[0]), 32'h81);
        check("m3_rx_byte1", 32'(rx_q[1]), 32'h7E);
        check("m3_ovf", 32'(ovf_cnt), 32'd0);
        check("m3_miso0_dummy", 32'(mi), 32'hFF);
        check("m3_miso1_dummy", 32'(mi2), 32'hFF);

        // Empty TX buffer at frame start: dummy byte and a single underflow.
        set_mode(1'b0, 1'b0, 1'b0);
        udf_cnt = 0;
        frame_start();
        push_tx(8'h5A);
        spi_xfer(8'h00, 8, mi);
        frame_end();
        check("udf_miso", 32'(mi), 32'hFF);
        check("udf_count", 32'(udf_cnt), 32'd1);
        check("udf_rx_data", 32'(rx_data_o), 32'h00);
        drain_rx();

        // Overflow: second byte dropped while the first is still held.
        ovf_cnt = 0;
        frame_start();
        spi_xfer(8'h11, 8, mi);
        check("ovf_none_yet", 32'(ovf_cnt), 32'd0);
        spi_xfer(8'h22, 8, mi);
        frame_end();
        check("ovf_count", 32'(ovf_cnt), 32'd1);
        check("ovf_rx_valid", 32'(rx_valid_o), 32'd1);
        check("ovf_rx_held", 32'(rx_data_o), 32'h11);
        drain_rx();

        // Abort after 5 bits, then a clean byte.
        abort_cnt = 0;
        frame_start();
        spi_xfer(8'hAA, 5, mi);
        frame_end();
        check("abort_count", 32'(abort_cnt), 32'd1);
        check("abort_rx_valid", 32'(rx_valid_o), 32'd0);
        frame_start();
        spi_xfer(8'h55, 8, mi);
        frame_end();
        check("abort_next_valid", 32'(rx_valid_o), 32'd1);
        check("abort_next_data", 32'(rx_data_o), 32'h55);
        check("abort_no_extra", 32'(abort_cnt), 32'd1);

        // Reset pulse mid-byte, rx_data still holding 55 beforehand.
        abort_cnt = 0;
        frame_start();
        spi_xfer(8'hF0, 3, mi);
        rst = 1'b1;
        tick(1);
        check("mrst_tx_ready", 32'(tx_ready_o), 32'd1);
        check("mrst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("mrst_rx_data",  32'(rx_data_o), 32'h00);
        check("mrst_miso",     32'({spi_miso_en_o, spi_miso_o}), 32'd0);
        check("mrst_busy",     32'(busy_o), 32'd0);
        check("mrst_pulses",   32'({ovf_o, udf_o, abort_o}), 32'd0);
        rst = 1'b0;
        tick(20);
        check("mrst_no_reentry", 32'(busy_o), 32'd0);
        frame_end();
        check("mrst_no_abort", 32'(abort_cnt), 32'd0);
        push_tx(8'hC3);
        frame_start();
        spi_xfer(8'h96, 8, mi);
        frame_end();
        check("mrst_miso", 32'(mi), 32'hC3);
        check("mrst_rx_data", 32'(rx_data_o), 32'h96);
        drain_rx();

        // Disable mid-frame: flush, no abort, and a fresh frame still works.
        abort_cnt = 0;
        push_tx(8'h77);
        frame_start();
        spi_xfer(8'h12, 8, mi);
        check("en_miso", 32'(mi), 32'h77);
        push_tx(8'h88);
        check("en_buf_full", 32'(tx_ready_o), 32'd0);
        spi_xfer(8'h34, 3, mi);
        en = 1'b0;
        tick(1);
        check("en_busy", 32'(busy_o), 32'd0);
        check("en_tx_flushed", 32'(tx_ready_o), 32'd1);
        check("en_rx_cleared", 32'(rx_valid_o), 32'd0);
        check("en_miso_en", 32'(spi_miso_en_o), 32'd0);
        frame_end();
        en = 1'b1;
        tick(4);
        check("en_no_abort", 32'(abort_cnt), 32'd0);
        frame_start();
        spi_xfer(8'hE7, 8, mi);
        frame_end();
        check("en_after_miso", 32'(mi), 32'hFF);
        check("en_after_rx", 32'(rx_data_o), 32'hE7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
